// File: rtl/store_narrow_rmw.sv
// ---------------------------------------------------------------------------
// store_narrow_rmw
//
// Store-path narrowing unit for the data memory. It takes a 32-bit register
// value and a store size (byte/half/word), truncates the value to that width
// and merges it into the addressed memory word by read-modify-write. The data
// memory has no byte enables, so a sub-word store must read the whole word
// first. This unit is the only writer of data memory.
//
// Parameters
//   ADDR_W     word-address width of data memory
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  store request
//   req_ready  unit can accept a request (high only while idle)
//   req_addr   byte address, ADDR_W+2 bits
//   req_data   register value; only the low 8/16/32 bits are stored
//   req_size   00 byte, 01 half, 10 word, 11 illegal
//   mem_addr   word address to data memory (0 while idle or in error)
//   mem_rd     read strobe; mem_rdata is valid the following cycle
//   mem_rdata  read data from data memory
//   mem_wr     write strobe
//   mem_wdata  write data (0 when not writing)
//   done       one-cycle pulse when a store commits
//   err        one-cycle pulse on a misaligned or illegal request
//
// Build option
//   STORE_FWD_EN  when defined, a last-write buffer (word address, data,
//                 valid) lets a sub-word store to the most recently written
//                 word skip the memory read and commit one cycle after
//                 acceptance.
// ---------------------------------------------------------------------------
module store_narrow_rmw #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Request latched at acceptance. Only the low half of the data is kept:
  // word stores go straight into merged_q, so the upper bits are never needed.
  logic [ADDR_W-1:0] lat_waddr;
  logic [1:0]        lat_lane;
  logic [1:0]        lat_size;
  logic [15:0]       lat_data;

  // Word to be written in WR: either the raw word-store data or the result of
  // merging the narrowed data into the read (or forwarded) word.
  logic [31:0]       merged_q;

  logic              accept;
  logic              req_bad;
  logic              req_word;
  logic              fwd_hit;

`ifdef STORE_FWD_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [31:0]       buf_data;
`endif

  // Replace the addressed byte or halfword lane of base with the narrowed
  // store data (little-endian lanes); every other bit comes from base.
  function automatic logic [31:0] merge_lane(
    input logic [31:0] base,
    input logic [15:0] data,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] r;
    r = base;
    if (size == SIZE_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (size == SIZE_HALF) begin
      if (lane[1]) begin
        r[31:16] = data;
      end else begin
        r[15:0] = data;
      end
    end
    return r;
  endfunction

  // Request classification, only meaningful while idle.
  always_comb begin
    accept   = (state == IDLE) && req_valid;
    req_bad  = (req_size == 2'b11) ||
               ((req_size == SIZE_HALF) && req_addr[0]) ||
               ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    req_word = (req_size == SIZE_WORD);
`ifdef STORE_FWD_EN
    fwd_hit  = buf_valid && !req_bad && !req_word &&
               (buf_addr == req_addr[ADDR_W+1:2]);
`else
    fwd_hit  = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Errors take priority over every other decode so that a
  // misaligned request can never reach memory.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_nxt = ERR;
          end else if (req_word || fwd_hit) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = WR;
      WR:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from state and registered datapath values only, so
  // there is no combinational path from req_* to mem_*.
  always_comb begin
    req_ready = (state == IDLE);
    mem_rd    = (state == RD);
    mem_wr    = (state == WR);
    done      = (state == WR);
    err       = (state == ERR);
    mem_addr  = '0;
    mem_wdata = '0;
    if ((state == RD) || (state == CAP) || (state == WR)) begin
      mem_addr = lat_waddr;
    end
    if (state == WR) begin
      mem_wdata = merged_q;
    end
  end

  // Datapath: latch the request on acceptance, build the merged word either
  // immediately (word store or forward hit) or when the read data arrives in
  // CAP. mem_rdata is sampled only in CAP, one cycle after the RD strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_waddr <= '0;
      lat_lane  <= '0;
      lat_size  <= '0;
      lat_data  <= '0;
      merged_q  <= '0;
    end else begin
      if (accept) begin
        lat_waddr <= req_addr[ADDR_W+1:2];
        lat_lane  <= req_addr[1:0];
        lat_size  <= req_size;
        lat_data  <= req_data[15:0];
        if (req_word) begin
          merged_q <= req_data;
        end
`ifdef STORE_FWD_EN
        else if (fwd_hit) begin
          merged_q <= merge_lane(buf_data, req_data[15:0], req_size,
                                 req_addr[1:0]);
        end
`endif
      end else if (state == CAP) begin
        merged_q <= merge_lane(mem_rdata, lat_data, lat_size, lat_lane);
      end
    end
  end

`ifdef STORE_FWD_EN
  // Last-write buffer: mirrors every word committed to memory, so it always
  // matches the memory contents at buf_addr while valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (state == WR) begin
      buf_valid <= 1'b1;
      buf_addr  <= lat_waddr;
      buf_data  <= merged_q;
    end
  end
`endif

endmodule

// File: tb/tb_store_narrow_rmw.sv
// ---------------------------------------------------------------------------
// tb_store_narrow_rmw
//
// Self-checking bench for store_narrow_rmw. A behavioural word memory answers
// mem_rd one cycle later and absorbs mem_wr. Expected writes are queued when a
// store is issued and compared by a monitor whenever mem_wr fires. A vector
// table covers word, byte and half stores across all lanes, truncation,
// error cases and the top address; hand-written sequences cover forwarding
// and a reset that lands in the middle of a read-modify-write.
// ---------------------------------------------------------------------------
module tb_store_narrow_rmw;

  localparam int ADDR_W = 10;
  localparam logic [31:0] MEM_DEFAULT = 32'h11223344;

`ifdef STORE_FWD_EN
  localparam int HIT_LAT = 1;
  localparam bit HIT_RD  = 1'b0;
`else
  localparam int HIT_LAT = 3;
  localparam bit HIT_RD  = 1'b1;
`endif

  typedef struct {
    logic [ADDR_W+1:0] addr;
    logic [31:0]       data;
    logic [1:0]        size;
    logic              exp_err;
    logic [31:0]       exp_word;
    int                exp_lat;
    logic              exp_rd;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_data = '0;
  logic [1:0]        req_size = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata = '0;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              err;

  logic [31:0]       mem [0:1023];
  bit                mem_vld [0:1023];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = '0;

  wr_t               sb_q [$];
  int                n_cmp = 0;
  int                n_bad = 0;
  vec_t              tbl [14];

  store_narrow_rmw #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural data memory; unwritten words read as MEM_DEFAULT.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem_vld[mem_addr] ? mem[mem_addr] : MEM_DEFAULT;
    end
    if (mem_wr) begin
      mem[mem_addr]     <= mem_wdata;
      mem_vld[mem_addr] <= 1'b1;
    end
    if (pre_we) begin
      mem[pre_addr]     <= pre_data;
      mem_vld[pre_addr] <= 1'b1;
    end
  end

  function automatic logic [31:0] z1(input logic b);
    return {31'b0, b};
  endfunction

  function automatic logic [31:0] za(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wr || done) begin
        checkOutput("wr_done_pair", z1(mem_wr), z1(done));
      end
      if (mem_wr || mem_rd) begin
        checkOutput("rd_wr_excl", z1(mem_wr && mem_rd), 32'd0);
      end
      if (done || err) begin
        checkOutput("done_err_excl", z1(done && err), 32'd0);
      end
      if (mem_wr) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_write: got addr 0x%03h data 0x%08h, want no write",
                   mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          checkOutput("wr_addr", za(mem_addr), za(e.addr));
          checkOutput("wr_data", mem_wdata, e.data);
        end
      end
    end
  end

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic presetWord(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Issue one store, follow it to done/err and check latency, read behaviour
  // and the return of req_ready. Written data is checked by the monitor.
  task automatic applyStimulus(input vec_t v, input string tag);
    int n;
    bit got;
    bit seen_rd;
    if (!v.exp_err) begin
      sb_q.push_back('{addr: v.addr[ADDR_W+1:2], data: v.exp_word});
    end
    @(negedge clk);
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    got = 1'b0;
    seen_rd = 1'b0;
    checkOutput({tag, "_busy"}, z1(req_ready), 32'd0);
    while ((n <= 10) && !got) begin
      if (mem_rd) begin
        seen_rd = 1'b1;
        checkOutput({tag, "_rd_addr"}, za(mem_addr), za(v.addr[ADDR_W+1:2]));
      end
      if (done || err) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s_timeout: got no done/err in 10 cycles, want one", tag);
    end else begin
      checkOutput({tag, "_lat"}, n, v.exp_lat);
      checkOutput({tag, "_err"}, z1(err), z1(v.exp_err));
      checkOutput({tag, "_rd_seen"}, z1(seen_rd), z1(v.exp_rd));
      if (err) begin
        checkOutput({tag, "_err_addr"}, za(mem_addr), 32'd0);
      end
      @(negedge clk);
      checkOutput({tag, "_ready"}, z1(req_ready), 32'd1);
    end
  endtask

  initial begin
    int done_cnt;

    // addr, data, size, exp_err, exp_word, exp_lat, exp_rd
    tbl[0]  = '{12'h008, 32'hDEADBEEF, 2'b10, 1'b0, 32'hDEADBEEF, 1, 1'b0};
    tbl[1]  = '{12'h005, 32'h123456AB, 2'b00, 1'b0, 32'h1122AB44, 3, 1'b1};
    tbl[2]  = '{12'h00E, 32'hFFFF8765, 2'b01, 1'b0, 32'h87653344, 3, 1'b1};
    tbl[3]  = '{12'h010, 32'h0000BEEF, 2'b01, 1'b0, 32'h1122BEEF, 3, 1'b1};
    tbl[4]  = '{12'h017, 32'h000000FF, 2'b00, 1'b0, 32'hFF223344, 3, 1'b1};
    tbl[5]  = '{12'h018, 32'hAAAAAA00, 2'b00, 1'b0, 32'h11223300, 3, 1'b1};
    tbl[6]  = '{12'h003, 32'h0000FFFF, 2'b01, 1'b1, 32'h00000000, 1, 1'b0};
    tbl[7]  = '{12'h006, 32'hCAFEF00D, 2'b10, 1'b1, 32'h00000000, 1, 1'b0};
    tbl[8]  = '{12'h020, 32'h12345678, 2'b11, 1'b1, 32'h00000000, 1, 1'b0};
    tbl[9]  = '{12'h00C, 32'h01020304, 2'b10, 1'b0, 32'h01020304, 1, 1'b0};
    tbl[10] = '{12'h00D, 32'hFFFFFF99, 2'b00, 1'b0, 32'h01029904, HIT_LAT, HIT_RD};
    tbl[11] = '{12'h00E, 32'h00000077, 2'b00, 1'b0, 32'h01779904, HIT_LAT, HIT_RD};
    tbl[12] = '{12'h012, 32'h5555CAFE, 2'b01, 1'b0, 32'hCAFEBEEF, 3, 1'b1};
    tbl[13] = '{12'hFFF, 32'h00000042, 2'b00, 1'b0, 32'h42223344, 3, 1'b1};

    $display("[TB] reset");
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", z1(req_ready), 32'd1);
    checkOutput("rst_mem_rd", z1(mem_rd), 32'd0);
    checkOutput("rst_mem_wr", z1(mem_wr), 32'd0);
    checkOutput("rst_done", z1(done), 32'd0);
    checkOutput("rst_err", z1(err), 32'd0);
    checkOutput("rst_mem_addr", za(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", z1(req_ready), 32'd1);

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i], $sformatf("v%0d", i));
    end

    $display("[TB] half store into upper lane");
    applyReset();
    presetWord(10'd1, MEM_DEFAULT);
    applyStimulus('{12'h006, 32'hFFFF8765, 2'b01, 1'b0, 32'h87653344, 3, 1'b1},
                  "half_hi");

    $display("[TB] back-to-back bytes to the same word");
    applyReset();
    presetWord(10'd1, MEM_DEFAULT);
    applyStimulus('{12'h005, 32'h000000AB, 2'b00, 1'b0, 32'h1122AB44, 3, 1'b1},
                  "fwd_first");
    applyStimulus('{12'h004, 32'h000000CD, 2'b00, 1'b0, 32'h1122ABCD, HIT_LAT, HIT_RD},
                  "fwd_second");

    $display("[TB] reset during read-modify-write");
    @(negedge clk);
    req_addr  = 12'h01E;
    req_data  = 32'h00001234;
    req_size  = 2'b01;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("abort_rd", z1(mem_rd), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", z1(req_ready), 32'd1);
    checkOutput("abort_mem_addr", za(mem_addr), 32'd0);
    checkOutput("abort_mem_wr", z1(mem_wr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("abort_no_done", done_cnt, 32'd0);
    checkOutput("abort_no_write", z1(mem_vld[7]), 32'd0);
    checkOutput("abort_ready_after", z1(req_ready), 32'd1);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
